des_feistel_mix: RTL

- Downstream neighbour of the S-box combine stage in the pipelined DES round.
- Takes the 32-bit concatenated S-box output for a round, applies the DES P-permutation, XORs the result with the round's left half, and forms the next {L,R} pair.
- Registered pipeline stage with a valid/ready handshake and a 2-entry skid buffer, so back-pressure from the next round or the final-permutation stage never drops data.

---
 rtl/des_pkg.sv | 33 +++
 rtl/des_feistel_mix_if.sv | 31 +++
 rtl/des_skid_buffer.sv | 85 ++++++++
 rtl/des_feistel_mix.sv | 60 ++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES definitions used by the round, key and final-permutation stages.
//   half_t      : 32-bit half block, bit 31 = DES bit 1
//   round_t     : 4-bit round index
//   P_TABLE     : DES P-permutation, entry k-1 gives the source DES bit of output DES bit k
//   p_permute() : applies P_TABLE to a half block
package des_pkg;

    typedef logic [31:0] half_t;
    typedef logic [3:0]  round_t;

    localparam int unsigned PAYLOAD_W = 32'd69;

    localparam int unsigned P_TABLE [32] = '{
        32'd16, 32'd7,  32'd20, 32'd21, 32'd29, 32'd12, 32'd28, 32'd17,
        32'd1,  32'd15, 32'd23, 32'd26, 32'd5,  32'd18, 32'd31, 32'd10,
        32'd2,  32'd8,  32'd24, 32'd14, 32'd32, 32'd27, 32'd3,  32'd9,
        32'd19, 32'd13, 32'd30, 32'd6,  32'd22, 32'd11, 32'd4,  32'd25
    };

    // DES bit n lives at vector index 32-n, so output DES bit k+1 sits at
    // index 31-k and takes its value from index 32-P[k].
    function automatic half_t p_permute(input half_t din);
        half_t      dout;
        logic [4:0] src;
        dout = 32'h0000_0000;
        for (int k = 0; k < 32; k++) begin
            src                = 5'(32'd32 - P_TABLE[k]);
            dout[5'(31 - k)]   = din[src];
        end
        return dout;
    endfunction

endpackage

// File: rtl/des_feistel_mix_if.sv
// Handshake/data bundle of the Feistel mix stage.
//   upstream  : inValid, inReady, sboxOut, leftIn, rightIn, roundIn
//   downstream: outValid, outReady, leftOut, rightOut, roundOut, lastOut
// slave  = the stage itself, master = whoever drives and consumes it.
interface des_feistel_mix_if;
    import des_pkg::*;

    logic   inValid;
    logic   inReady;
    half_t  sboxOut;
    half_t  leftIn;
    half_t  rightIn;
    round_t roundIn;
    logic   outValid;
    logic   outReady;
    half_t  leftOut;
    half_t  rightOut;
    round_t roundOut;
    logic   lastOut;

    modport slave (
        input  inValid, sboxOut, leftIn, rightIn, roundIn, outReady,
        output inReady, outValid, leftOut, rightOut, roundOut, lastOut
    );

    modport master (
        output inValid, sboxOut, leftIn, rightIn, roundIn, outReady,
        input  inReady, outValid, leftOut, rightOut, roundOut, lastOut
    );

endinterface

// File: rtl/des_skid_buffer.sv
// Generic two-entry (output register + skid register) valid/ready stage.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake, in_ready is a flop (= !skid full)
//   in_data             : upstream payload
//   out_valid/out_ready : downstream handshake
//   out_data            : registered payload, held stable while stalled
module des_skid_buffer #(
    parameter int unsigned WIDTH = 32'd69
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_full_q, skid_full_d;
    logic             in_ready_q,  in_ready_d;
    logic             accept;
    logic             consume;

    // Next-state for output register, skid register and the registered ready.
    always_comb begin
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;
        accept      = in_valid && in_ready_q;
        consume     = out_valid_q && out_ready;

        if (!out_valid_q || consume) begin
            // Output slot frees up this edge: the skid beat is older, so it
            // goes first. in_ready is low whenever the skid is full, so no
            // new beat can arrive in that case.
            if (skid_full_q) begin
                out_data_d  = skid_data_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            // Output stalled: park an incoming beat in the skid register.
            if (accept) begin
                skid_data_d = in_data;
                skid_full_d = 1'b1;
            end else begin
                skid_full_d = skid_full_q;
            end
        end

        in_ready_d = !skid_full_d;
    end

    // State registers with synchronous reset that discards all buffered beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            skid_data_q <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/des_feistel_mix.sv
// DES round tail: P-permutes the S-box output, XORs it into the left half
// and forms the next {L,R} pair, registered behind a skid buffer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : des_feistel_mix_if.slave
//                in : inValid, sboxOut, leftIn, rightIn, roundIn, outReady
//                out: inReady, outValid, leftOut, rightOut, roundOut, lastOut
// Parameters:
//   LAST_ROUND   : round on which the L/R swap may be suppressed
//   SWAP_ON_LAST : 1 = suppress the swap on LAST_ROUND, 0 = always swap
module des_feistel_mix
    import des_pkg::*;
#(
    parameter int unsigned LAST_ROUND   = 32'd15,
    parameter bit          SWAP_ON_LAST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    des_feistel_mix_if.slave   bus
);

    localparam round_t LAST_R = round_t'(LAST_ROUND);

    half_t                f_val;
    half_t                left_nxt;
    half_t                right_nxt;
    logic                 is_last;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    // Feistel mix and swap select; lastOut is flagged regardless of swap mode.
    always_comb begin
        f_val   = p_permute(bus.sboxOut);
        is_last = (bus.roundIn == LAST_R);
        if (SWAP_ON_LAST && is_last) begin
            // Final round keeps the halves in place to yield R16L16.
            left_nxt  = bus.leftIn ^ f_val;
            right_nxt = bus.rightIn;
        end else begin
            left_nxt  = bus.rightIn;
            right_nxt = bus.leftIn ^ f_val;
        end
        in_payload = {left_nxt, right_nxt, bus.roundIn, is_last};
    end

    des_skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.inValid),
        .in_ready  (bus.inReady),
        .in_data   (in_payload),
        .out_valid (bus.outValid),
        .out_ready (bus.outReady),
        .out_data  (out_payload)
    );

    assign {bus.leftOut, bus.rightOut, bus.roundOut, bus.lastOut} = out_payload;

endmodule
